opb_register_bank_ppc2simulink: RTL and testbench
=================================================

Name: opb_register_bank_ppc2simulink

Overview:
- Parametrised successor to the single PPC-to-Simulink software register.
- Bank of C_NUM_REGS 32-bit registers that software writes over the OPB slave interface, with byte enables and readback.
- Writes land in shadow registers and reach the fabric together on a commit, with a one-cycle load strobe and a changed-register mask.
- Single clock domain: the user logic runs on OPB_Clk.

Parameters:
C_BASEADDR, 32'h01003200, first byte address of the bank
C_HIGHADDR, 32'h010032FF, last decoded byte address
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width (only 32 is supported)
C_NUM_REGS, 8, number of data registers, 1..16
C_AUTO_COMMIT, 0, 1 = every data write commits immediately
C_RESET_VALUE, 32'h00000000, reset value of every shadow and output word

Ports:
OPB_Clk  in  1  single clock for the bus and user side
OPB_Rst_n  in  1  asynchronous active-low reset
OPB_ABus  in  [0:31]  byte address
OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data; zero whenever Sl_xferAck=0
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
user_data_out  out  32*C_NUM_REGS  committed words; reg i at [32i+31:32i]
user_load  out  1  one-cycle strobe after a commit
user_load_mask  out  C_NUM_REGS  registers written since the previous commit; valid with user_load

Behaviour:
- Reset (async assert, sync release). All of the following take their reset values:
  - shadow and user_data_out = C_RESET_VALUE
  - user_load = 0, user_load_mask = 0, pending mask = 0, commit counter = 0
  - Sl_xferAck = 0, Sl_DBus = 0
  - FSM returns to IDLE
- Address map, with offset = OPB_ABus - C_BASEADDR:
  - Data reg i at offset 4i, word aligned; ABus[30:31] are ignored.
  - Control word at offset 4*C_NUM_REGS.
  - Hit = OPB_select && C_BASEADDR <= ABus <= C_HIGHADDR.
- FSM states IDLE, ACK, HOLD:
  - IDLE -> ACK when hit is sampled.
  - ACK lasts exactly one cycle. Sl_xferAck=1, Sl_DBus is valid, and any write is performed in this cycle (registered on the edge that ends ACK).
  - ACK -> HOLD -> IDLE, so a new transfer can be accepted no earlier than 3 cycles after the previous one.
  - Latency: select sampled -> xferAck on the next cycle.
  - No hit: the block never acks and lets the bus time out.
- Data write: each shadow byte is updated only where its BE bit is 1. Sets pending[i] even when all BE bits are 0.
- Data read: returns shadow[i] (see Optional Feature).
- Control write:
  - Value bit 0 (DBus[31]) = 1 requests a commit. All other bits are ignored.
  - The write is honoured only when BE[3]=1.
  - A commit request with pending = 0 still commits: user_load pulses with mask 0.
- Control read: DBus[16:31] = commit counter (16-bit, wraps from 0xFFFF to 0); DBus[0:15] = pending mask, zero-extended.
- Commit, in the cycle after ACK:
  - user_data_out <= shadow
  - user_load = 1 for one cycle
  - user_load_mask <= pending; user_load_mask holds its value until the next commit
  - pending <= 0
  - counter += 1
- C_AUTO_COMMIT=1: every data write commits all registers with mask = one-hot(i). Control writes are still accepted.
- Decoded but unused offsets (beyond the control word, up to C_HIGHADDR): acked, read 0, writes ignored.
- Reset asserted mid-transfer: the ack is dropped at once. Neither the partial write nor the commit takes effect.

Optional Feature:
Macro OPB_REGBANK_READBACK_USER_EN.
- Defined: data-register reads return user_data_out[i], the committed value.
- Undefined: data-register reads return shadow[i].
- All other behaviour is identical with or without the macro.

Decomposition:
- Package opb_regbank_pkg holds:
  - FSM state typedef (IDLE/ACK/HOLD)
  - CTRL_COMMIT_BIT = 0
  - MAX_REGS = 16
  - COUNTER_W = 16
  - function byte_merge(old, new, be)
- One sub-module, opb_regbank_slave_if: address decode, FSM and the ack/read-data mux. It exposes wr_en, rd_en, reg_idx and is_ctrl to the top level, which owns the shadow, commit and output logic.

Test Plan:
- Reset, then read reg 0 -> 0x00000000 with xferAck exactly 1 cycle after select; Sl_DBus=0 outside ack.
- Write reg 2 = 0xDEADBEEF with BE=1111, then write reg 2 = 0x11223344 with BE=0101 -> shadow 0xDE22BE44; user_data_out[95:64] stays 0; control read shows pending=0x0004.
- Write reg 0 = 0xA5A5A5A5, reg 7 = 0x5A5A5A5A, then write control = 1 -> one cycle after ack: user_load=1 for 1 cycle, mask=0x81, both words visible, counter=1, pending=0.
- Control write = 1 with BE=1110 -> no commit, counter unchanged; then BE=1111 with pending=0 -> user_load pulses, mask=0.
- C_AUTO_COMMIT=1: write reg 3 = 0x00000042 -> user_load pulses with mask=0x08 and the word appears without a control write.
- Assert OPB_Rst_n low during ACK of a commit write -> outputs return to C_RESET_VALUE, no user_load pulse; address C_HIGHADDR+4 -> never acked.

Source files
------------

// File: rtl/opb_regbank_pkg.sv
// Shared types, constants and helpers for the OPB register bank.
package opb_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } slave_state_t;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int MAX_REGS        = 16;
    localparam int COUNTER_W       = 16;
    localparam int IDX_W           = $clog2(MAX_REGS);

    // be[b] selects bits [8b+7:8b] of the numeric word (bus byte lane 3-b).
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/opb_regbank_slave_if.sv
// OPB slave front end: address decode, IDLE/ACK/HOLD handshake and the
// registered read-data lane that is only non-zero while acknowledging.
module opb_regbank_slave_if
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] BASEADDR = 32'h01003200,
    parameter logic [31:0] HIGHADDR = 32'h010032FF,
    parameter int          NUM_REGS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      addr,
    input  logic             rnw,
    input  logic             select,
    input  logic [31:0]      rd_word,
    output logic [IDX_W-1:0] reg_idx,
    output logic             is_ctrl,
    output logic             wr_en,
    output logic             rd_en,
    output logic [31:0]      sl_dbus,
    output logic             sl_xfer_ack
);

    slave_state_t     state_r;
    logic             ack_r;
    logic [31:0]      dbus_r;
    logic             rnw_r;
    logic [IDX_W-1:0] idx_r;
    logic             data_r;
    logic             ctrl_r;

    logic             hit_s;
    logic [31:0]      offset_s;
    logic [29:0]      word_s;
    logic             dec_data_s;
    logic             dec_ctrl_s;
    logic             unused_low_s;

    assign hit_s        = select && (addr >= BASEADDR) && (addr <= HIGHADDR);
    assign offset_s     = addr - BASEADDR;
    assign word_s       = offset_s[31:2];
    assign unused_low_s = ^offset_s[1:0];
    assign dec_data_s   = (word_s < 30'(NUM_REGS));
    assign dec_ctrl_s   = (word_s == 30'(NUM_REGS));

    // Live decode feeds the read mux in IDLE; the latched decode steers the write in ACK.
    always_comb begin
        reg_idx = idx_r;
        is_ctrl = ctrl_r;
        if (state_r == IDLE) begin
            reg_idx = word_s[IDX_W-1:0];
            is_ctrl = dec_ctrl_s;
        end else begin
            reg_idx = idx_r;
            is_ctrl = ctrl_r;
        end
    end

    // Transfer handshake FSM with registered ack and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
            dbus_r  <= 32'h0000_0000;
            rnw_r   <= 1'b0;
            idx_r   <= '0;
            data_r  <= 1'b0;
            ctrl_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hit_s) begin
                        state_r <= ACK;
                        ack_r   <= 1'b1;
                        rnw_r   <= rnw;
                        idx_r   <= word_s[IDX_W-1:0];
                        data_r  <= dec_data_s;
                        ctrl_r  <= dec_ctrl_s;
                        dbus_r  <= (rnw && (dec_data_s || dec_ctrl_s)) ? rd_word : 32'h0000_0000;
                    end else begin
                        ack_r  <= 1'b0;
                        dbus_r <= 32'h0000_0000;
                    end
                end
                ACK: begin
                    state_r <= HOLD;
                    ack_r   <= 1'b0;
                    dbus_r  <= 32'h0000_0000;
                end
                HOLD: begin
                    state_r <= IDLE;
                    ack_r   <= 1'b0;
                    dbus_r  <= 32'h0000_0000;
                end
                default: begin
                    state_r <= IDLE;
                    ack_r   <= 1'b0;
                    dbus_r  <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign wr_en       = (state_r == ACK) && !rnw_r && (data_r || ctrl_r);
    assign rd_en       = (state_r == ACK) && rnw_r;
    assign sl_dbus     = dbus_r;
    assign sl_xfer_ack = ack_r;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// Bank of software-writable 32-bit registers with shadow/commit semantics.
// Optional macro OPB_REGBANK_READBACK_USER_EN: data reads return committed words.
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h01003200,
    parameter logic [31:0] C_HIGHADDR    = 32'h010032FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_REGS    = 8,
    parameter int          C_AUTO_COMMIT = 0,
    parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
    input  logic                       OPB_Clk,
    input  logic                       OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
    input  logic [0:3]                 OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
    input  logic                       OPB_RNW,
    input  logic                       OPB_select,
    input  logic                       OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
    output logic                       Sl_xferAck,
    output logic                       Sl_errAck,
    output logic                       Sl_retry,
    output logic                       Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0]   user_data_out,
    output logic                       user_load,
    output logic [C_NUM_REGS-1:0]      user_load_mask
);

    localparam logic AUTO_COMMIT = (C_AUTO_COMMIT != 0);

    logic [31:0]             addr_s;
    logic [31:0]             wdata_s;
    logic [3:0]              be_s;
    logic [31:0]             rd_word_s;
    logic [31:0]             sl_dbus_s;
    logic [IDX_W-1:0]        reg_idx_s;
    logic                    is_ctrl_s;
    logic                    wr_en_s;
    logic                    rd_en_s;
    logic                    data_wr_s;
    logic                    commit_s;
    logic [C_NUM_REGS-1:0]   onehot_s;
    logic [C_NUM_REGS-1:0]   pending_nxt_s;
    logic [C_NUM_REGS-1:0]   mask_nxt_s;
    logic [31:0]             shadow_nxt_s [C_NUM_REGS];
    logic                    unused_s;

    logic [31:0]             shadow_r [C_NUM_REGS];
    logic [32*C_NUM_REGS-1:0] user_data_r;
    logic [C_NUM_REGS-1:0]   pending_r;
    logic [C_NUM_REGS-1:0]   mask_r;
    logic                    load_r;
    logic [COUNTER_W-1:0]    count_r;

    // The bus is MSB-first, so bit 0 of each vector becomes the numeric MSB here.
    assign addr_s   = OPB_ABus;
    assign wdata_s  = OPB_DBus;
    assign be_s     = OPB_BE;
    assign unused_s = OPB_seqAddr ^ rd_en_s;

    opb_regbank_slave_if #(
        .BASEADDR (C_BASEADDR),
        .HIGHADDR (C_HIGHADDR),
        .NUM_REGS (C_NUM_REGS)
    ) u_slave_if (
        .clk         (OPB_Clk),
        .rst_n       (OPB_Rst_n),
        .addr        (addr_s),
        .rnw         (OPB_RNW),
        .select      (OPB_select),
        .rd_word     (rd_word_s),
        .reg_idx     (reg_idx_s),
        .is_ctrl     (is_ctrl_s),
        .wr_en       (wr_en_s),
        .rd_en       (rd_en_s),
        .sl_dbus     (sl_dbus_s),
        .sl_xfer_ack (Sl_xferAck)
    );

    // One-hot select of the addressed data register.
    always_comb begin
        onehot_s = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            onehot_s[i] = (reg_idx_s == IDX_W'(i));
        end
    end

    assign data_wr_s = wr_en_s && !is_ctrl_s;
    assign commit_s  = (wr_en_s && is_ctrl_s && be_s[0] && wdata_s[CTRL_COMMIT_BIT])
                     || (data_wr_s && AUTO_COMMIT);

    // Shadow contents after this cycle's write; a commit publishes this view.
    always_comb begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (data_wr_s && onehot_s[i]) begin
                shadow_nxt_s[i] = byte_merge(shadow_r[i], wdata_s, be_s);
            end else begin
                shadow_nxt_s[i] = shadow_r[i];
            end
        end
    end

    // Pending-mask update and the mask reported with the next load strobe.
    always_comb begin
        pending_nxt_s = pending_r;
        mask_nxt_s    = pending_r;
        if (commit_s) begin
            pending_nxt_s = '0;
        end else if (data_wr_s) begin
            pending_nxt_s = pending_r | onehot_s;
        end else begin
            pending_nxt_s = pending_r;
        end
        if (data_wr_s && AUTO_COMMIT) begin
            mask_nxt_s = onehot_s;
        end else begin
            mask_nxt_s = pending_r;
        end
    end

    // Shadow, pending and committed-output state.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                shadow_r[i] <= C_RESET_VALUE;
            end
            user_data_r <= {C_NUM_REGS{C_RESET_VALUE}};
            pending_r   <= '0;
            mask_r      <= '0;
            load_r      <= 1'b0;
            count_r     <= '0;
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                shadow_r[i] <= shadow_nxt_s[i];
            end
            pending_r <= pending_nxt_s;
            load_r    <= commit_s;
            if (commit_s) begin
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    user_data_r[32*i +: 32] <= shadow_nxt_s[i];
                end
                mask_r  <= mask_nxt_s;
                count_r <= count_r + COUNTER_W'(1);
            end
        end
    end

    // Read word: control status, or the addressed data register.
    always_comb begin
        rd_word_s = 32'h0000_0000;
        if (is_ctrl_s) begin
            rd_word_s[COUNTER_W-1:0]           = count_r;
            rd_word_s[COUNTER_W +: C_NUM_REGS] = pending_r;
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (onehot_s[i]) begin
`ifdef OPB_REGBANK_READBACK_USER_EN
                    rd_word_s = user_data_r[32*i +: 32];
`else
                    rd_word_s = shadow_r[i];
`endif
                end
            end
        end
    end

    assign Sl_DBus        = sl_dbus_s;
    assign Sl_errAck      = 1'b0;
    assign Sl_retry       = 1'b0;
    assign Sl_toutSup     = 1'b0;
    assign user_data_out  = user_data_r;
    assign user_load      = load_r;
    assign user_load_mask = mask_r;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: a manual-commit and an auto-commit
// instance share one bus; both are checked against a word-level model.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] B     = 32'h01003200;
    localparam logic [31:0] HIGH  = 32'h010032FF;
    localparam int          NREGS = 8;
`ifdef OPB_REGBANK_READBACK_USER_EN
    localparam logic [31:0] RD2 = 32'h00000000;
`else
    localparam logic [31:0] RD2 = 32'hDE22BE44;
`endif

    logic        clk = 1'b0;
    logic        OPB_Rst_n;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW, OPB_select, OPB_seqAddr;

    logic [0:31]  dbus0, dbus1;
    logic         ack0, ack1, err0, err1, rty0, rty1, tos0, tos1, load0, load1;
    logic [255:0] udo0, udo1;
    logic [7:0]   mask0, mask1;

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink dut0 (
        .OPB_Clk(clk), .OPB_Rst_n(OPB_Rst_n), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
        .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
        .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(dbus0), .Sl_xferAck(ack0), .Sl_errAck(err0),
        .Sl_retry(rty0), .Sl_toutSup(tos0), .user_data_out(udo0), .user_load(load0),
        .user_load_mask(mask0)
    );

    opb_register_bank_ppc2simulink #(.C_AUTO_COMMIT(1)) dut1 (
        .OPB_Clk(clk), .OPB_Rst_n(OPB_Rst_n), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
        .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
        .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(dbus1), .Sl_xferAck(ack1), .Sl_errAck(err1),
        .Sl_retry(rty1), .Sl_toutSup(tos1), .user_data_out(udo1), .user_load(load1),
        .user_load_mask(mask1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_shadow [NREGS];
    logic [31:0] m_udo [2][NREGS];
    logic [7:0]  m_pend [2];
    logic [7:0]  m_mask [2];
    logic [15:0] m_cnt [2];
    bit          m_load [2];

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_shadow[i] = 32'h0;
            m_udo[0][i] = 32'h0;
            m_udo[1][i] = 32'h0;
        end
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 8'h0; m_mask[k] = 8'h0; m_cnt[k] = 16'h0; m_load[k] = 1'b0;
        end
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return (a >= B) && (a <= HIGH);
    endfunction

    function automatic logic [31:0] exp_read(input int inst, input logic [31:0] a);
        int w;
        if (!in_range(a)) return 32'h0;
        w = int'((a - B) >> 2);
        if (w < NREGS) begin
`ifdef OPB_REGBANK_READBACK_USER_EN
            return m_udo[inst][w];
`else
            return m_shadow[w];
`endif
        end
        if (w == NREGS) return {8'h00, m_pend[inst], m_cnt[inst]};
        return 32'h0;
    endfunction

    function automatic void model_commit(input int inst, input logic [7:0] mask);
        for (int i = 0; i < NREGS; i++) m_udo[inst][i] = m_shadow[i];
        m_mask[inst] = mask;
        m_pend[inst] = 8'h0;
        m_cnt[inst]  = m_cnt[inst] + 16'h1;
        m_load[inst] = 1'b1;
    endfunction

    // be[3-k] is bus lane BE[k], which covers DBus[8k:8k+7] = numeric bits [31-8k -: 8].
    function automatic void model_write(input logic [31:0] a, input logic [3:0] be,
                                        input logic [31:0] d);
        int w;
        m_load[0] = 1'b0;
        m_load[1] = 1'b0;
        if (!in_range(a)) return;
        w = int'((a - B) >> 2);
        if (w < NREGS) begin
            for (int k = 0; k < 4; k++)
                if (be[3-k]) m_shadow[w][31-8*k -: 8] = d[31-8*k -: 8];
            m_pend[0] = m_pend[0] | (8'h1 << w);
            model_commit(1, 8'h1 << w);
        end else if (w == NREGS && be[0] && d[0]) begin
            model_commit(0, m_pend[0]);
            model_commit(1, m_pend[1]);
        end
    endfunction

    function automatic logic [255:0] pack(input int inst);
        logic [255:0] v;
        for (int i = 0; i < NREGS; i++) v[32*i +: 32] = m_udo[inst][i];
        return v;
    endfunction

    // ---------------- bus transfer ----------------
    logic [31:0]  cap_rd0, cap_rd1, cap_idle_dbus;
    bit           cap_ack0, cap_ack1, cap_ties, cap_ack_after, cap_load0, cap_load1, cap_load_next;
    logic [7:0]   cap_mask0, cap_mask1;
    logic [255:0] cap_udo0, cap_udo1;
    int           cap_lat;

    task automatic xfer(input bit rnw, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d);
        @(negedge clk);
        OPB_select = 1'b1; OPB_RNW = rnw; OPB_ABus = a; OPB_BE = be; OPB_DBus = d;
        cap_ack0 = 1'b0;
        cap_lat  = 0;
        while (!cap_ack0 && cap_lat < 8) begin
            @(posedge clk); #1;
            cap_lat++;
            cap_ack0 = ack0;
        end
        cap_ack1 = ack1;
        cap_rd0  = dbus0;
        cap_rd1  = dbus1;
        cap_ties = err0 | err1 | rty0 | rty1 | tos0 | tos1;
        if (cap_ack0) begin
            @(posedge clk); #1;
        end
        OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_ABus = 32'h0; OPB_BE = 4'h0; OPB_DBus = 32'h0;
        cap_idle_dbus = dbus0 | dbus1;
        cap_ack_after = ack0 | ack1;
        cap_load0 = load0;  cap_load1 = load1;
        cap_mask0 = mask0;  cap_mask1 = mask1;
        cap_udo0  = udo0;   cap_udo1  = udo1;
        @(posedge clk); #1;
        cap_load_next = load0 | load1;
    endtask

    task automatic run_and_check(input bit rnw, input logic [31:0] a, input logic [3:0] be,
                                 input logic [31:0] d);
        bit          hit;
        logic [31:0] e0, e1;
        hit = in_range(a);
        e0  = exp_read(0, a);
        e1  = exp_read(1, a);
        xfer(rnw, a, be, d);
        check("ack0", cap_ack0, hit);
        check("ack1", cap_ack1, hit);
        if (hit) check("ack_latency", cap_lat, 1);
        if (rnw) begin
            check("rdata0", cap_rd0, e0);
            check("rdata1", cap_rd1, e1);
        end
        check("tied_outputs", cap_ties, 1'b0);
        if (!rnw) model_write(a, be, d);
        else begin
            m_load[0] = 1'b0;
            m_load[1] = 1'b0;
        end
        check("load0", cap_load0, m_load[0]);
        check("load1", cap_load1, m_load[1]);
        check("mask0", cap_mask0, m_mask[0]);
        check("mask1", cap_mask1, m_mask[1]);
        check("udo0", cap_udo0, pack(0));
        check("udo1", cap_udo1, pack(1));
        check("dbus_idle_zero", cap_idle_dbus, 32'h0);
        check("ack_one_cycle", cap_ack_after, 1'b0);
        check("load_one_cycle", cap_load_next, 1'b0);
    endtask

    // ---------------- directed vector table (manual-commit instance) ----------------
    typedef struct {
        bit          rnw;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        bit          exp_ack;
        logic [31:0] exp_rd;
        bit          exp_load;
        logic [7:0]  exp_mask;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rnw, input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] d, input bit ea, input logic [31:0] er,
                                input bit el, input logic [7:0] em);
        vec_t v;
        v.rnw = rnw; v.addr = a; v.be = be; v.data = d;
        v.exp_ack = ea; v.exp_rd = er; v.exp_load = el; v.exp_mask = em;
        vecs.push_back(v);
    endfunction

    initial begin
        OPB_Rst_n = 1'b0; OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_seqAddr = 1'b0;
        OPB_ABus = 32'h0; OPB_BE = 4'h0; OPB_DBus = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_udo", {udo1, udo0} == 512'h0, 1'b1);
        check("rst_ack_load", {ack1, ack0, load1, load0}, 4'h0);
        @(negedge clk);
        OPB_Rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_dbus", {dbus1, dbus0}, 64'h0);
        check("rst_mask", {mask1, mask0}, 16'h0);

        //   rnw   addr         be     data            ack  rd             load mask
        add(1'b1, B,           4'hF, 32'h0,          1'b1, 32'h0,        1'b0, 8'h00);
        add(1'b0, B + 32'h08,  4'hF, 32'hDEADBEEF,   1'b1, 32'h0,        1'b0, 8'h00);
        add(1'b0, B + 32'h08,  4'h5, 32'h11223344,   1'b1, 32'h0,        1'b0, 8'h00);
        add(1'b1, B + 32'h08,  4'hF, 32'h0,          1'b1, RD2,          1'b0, 8'h00);
        add(1'b1, B + 32'h20,  4'hF, 32'h0,          1'b1, 32'h00040000, 1'b0, 8'h00);
        add(1'b0, B + 32'h20,  4'hE, 32'h00000001,   1'b1, 32'h0,        1'b0, 8'h00);
        add(1'b1, B + 32'h20,  4'hF, 32'h0,          1'b1, 32'h00040000, 1'b0, 8'h00);
        add(1'b0, B + 32'h20,  4'hF, 32'h00000001,   1'b1, 32'h0,        1'b1, 8'h04);
        add(1'b0, B,           4'hF, 32'hA5A5A5A5,   1'b1, 32'h0,        1'b0, 8'h04);
        add(1'b0, B + 32'h1C,  4'hF, 32'h5A5A5A5A,   1'b1, 32'h0,        1'b0, 8'h04);
        add(1'b0, B + 32'h20,  4'hF, 32'h00000001,   1'b1, 32'h0,        1'b1, 8'h81);
        add(1'b1, B + 32'h20,  4'hF, 32'h0,          1'b1, 32'h00000002, 1'b0, 8'h81);
        add(1'b0, B + 32'h20,  4'hF, 32'h00000001,   1'b1, 32'h0,        1'b1, 8'h00);
        add(1'b0, B + 32'h20,  4'hF, 32'hFFFFFFFE,   1'b1, 32'h0,        1'b0, 8'h00);
        add(1'b1, B + 32'h20,  4'hF, 32'h0,          1'b1, 32'h00000003, 1'b0, 8'h00);
        add(1'b1, B + 32'h1C,  4'hF, 32'h0,          1'b1, 32'h5A5A5A5A, 1'b0, 8'h00);
        add(1'b1, B + 32'h40,  4'hF, 32'h0,          1'b1, 32'h0,        1'b0, 8'h00);
        add(1'b0, B + 32'h40,  4'hF, 32'hFFFFFFFF,   1'b1, 32'h0,        1'b0, 8'h00);
        add(1'b1, B + 32'h20,  4'hF, 32'h0,          1'b1, 32'h00000003, 1'b0, 8'h00);
        add(1'b1, HIGH,        4'hF, 32'h0,          1'b1, 32'h0,        1'b0, 8'h00);
        add(1'b1, HIGH + 32'h4, 4'hF, 32'h0,         1'b0, 32'h0,        1'b0, 8'h00);
        add(1'b1, B - 32'h4,   4'hF, 32'h0,          1'b0, 32'h0,        1'b0, 8'h00);
        add(1'b1, B + 32'h03,  4'hF, 32'h0,          1'b1, 32'hA5A5A5A5, 1'b0, 8'h00);

        foreach (vecs[i]) begin
            run_and_check(vecs[i].rnw, vecs[i].addr, vecs[i].be, vecs[i].data);
            check("tbl_ack", cap_ack0, vecs[i].exp_ack);
            if (vecs[i].rnw) check("tbl_rdata", cap_rd0, vecs[i].exp_rd);
            check("tbl_load", cap_load0, vecs[i].exp_load);
            check("tbl_mask", cap_mask0, vecs[i].exp_mask);
        end

        // Auto-commit instance publishes a data write without any control write.
        run_and_check(1'b0, B + 32'h0C, 4'hF, 32'h00000042);
        check("auto_load", cap_load1, 1'b1);
        check("auto_mask", cap_mask1, 8'h08);
        check("auto_word3", cap_udo1[127:96], 32'h00000042);
        check("manual_no_load", cap_load0, 1'b0);

        // Randomised traffic against the model.
        for (int n = 0; n < 200; n++) begin
            int          r;
            logic [31:0] a, d;
            r = $urandom_range(0, 19);
            if (r < 8)       a = B + 32'(4 * r) + 32'($urandom_range(0, 3));
            else if (r < 12) a = B + 32'h20 + 32'($urandom_range(0, 3));
            else if (r < 17) a = B + 32'(4 * $urandom_range(9, 63)) + 32'($urandom_range(0, 3));
            else if (r < 19) a = B + 32'h100 + 32'(4 * $urandom_range(0, 15));
            else             a = B - 32'(4 * $urandom_range(1, 16));
            d = $urandom;
            run_and_check(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), d);
        end

        // Reset asserted during the ACK of a commit write.
        run_and_check(1'b0, B + 32'h04, 4'hF, 32'h12345678);
        @(negedge clk);
        OPB_select = 1'b1; OPB_RNW = 1'b0; OPB_ABus = B + 32'h20; OPB_BE = 4'hF; OPB_DBus = 32'h1;
        @(posedge clk); #1;
        check("rst_mid_ack_seen", ack0, 1'b1);
        OPB_Rst_n = 1'b0;
        #1;
        check("rst_mid_ack_drop", {ack1, ack0}, 2'b00);
        OPB_select = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_mid_no_load", {load1, load0}, 2'b00);
        end
        @(negedge clk);
        OPB_Rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("rst_mid_udo", {udo1, udo0} == 512'h0, 1'b1);
        check("rst_mid_mask", {mask1, mask0}, 16'h0);
        run_and_check(1'b1, B + 32'h04, 4'hF, 32'h0);
        check("rst_mid_shadow", cap_rd0, 32'h0);
        run_and_check(1'b1, B + 32'h20, 4'hF, 32'h0);
        check("rst_mid_ctrl", cap_rd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
